// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register slice.
// Occupancy width helper sizes the optional occ port (PIPE_REG_CHAIN_OCC_EN).
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 8;
  localparam int PIPE_MAX_WIDTH = 48;

  function automatic int OCC_W(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline stage: data register, valid bit and its ready term.
// A stage accepts new contents whenever it is empty or its successor is moving.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             ce,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             nxt_rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign rdy   = !valid_q || nxt_rdy;
  assign valid = valid_q;
  assign data  = data_q;

  // Flush wins over any transfer; CE low freezes everything.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ce) begin
      if (flush) begin
        valid_d = 1'b0;
        data_d  = RST_VAL;
      end else if (rdy) begin
        valid_d = src_valid;
        data_d  = src_data;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain of DEPTH pipe_stage slices with valid/ready handshake.
// Define PIPE_REG_CHAIN_OCC_EN to add the registered occupancy output occ.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             CE,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [OCC_W(DEPTH)-1:0] occ
`endif
);

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be within 1..%0d", PIPE_MAX_DEPTH);
  end
  if (WIDTH < 1 || WIDTH > PIPE_MAX_WIDTH) begin : g_bad_width
    $error("pipe_reg_chain: WIDTH must be within 1..%0d", PIPE_MAX_WIDTH);
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [DEPTH-1:0] v_nxt;
`endif

  // Ready terms are kept per block so the backward chain is a set of scalars.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic             nxt_rdy_w;
    logic             rdy_w;

    if (gi == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = v[gi-1];
      assign src_d = d[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign nxt_rdy_w = out_ready;
    end else begin : g_link
      assign nxt_rdy_w = g_stage[gi+1].rdy_w;
    end

    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .RST       (RST),
      .ce        (CE),
      .flush     (flush),
      .src_valid (src_v),
      .src_data  (src_d),
      .nxt_rdy   (nxt_rdy_w),
      .valid     (v[gi]),
      .data      (d[gi]),
      .rdy       (rdy_w)
    );

`ifdef PIPE_REG_CHAIN_OCC_EN
    assign v_nxt[gi] = !CE   ? v[gi] :
                       flush ? 1'b0  :
                       rdy_w ? src_v : v[gi];
`endif
  end

  assign in_ready  = CE && !flush && g_stage[0].rdy_w;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OW = OCC_W(DEPTH);

  logic [OW-1:0] occ_q, occ_d;

  // Count the valid bits as they will be after this edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios then random traffic,
// compared against a word/position reference model.
module tb_pipe_reg_chain;
  import pipe_pkg::*;

  localparam int             W  = 18;
  localparam int             D  = 3;
  localparam logic [W-1:0]   RV = 18'h15A5A;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         CE = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [OCC_W(D)-1:0] occ;
`endif

  pipe_reg_chain #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .CE        (CE),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words in flight, oldest first, each with its stage index.
  int           mpos[$];
  logic [W-1:0] mdat[$];
  logic         rst_pending = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic ce, input logic fl);
    int   np[$];
    int   ahead;
    logic irdy;
    logic exp_ov;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    CE        = ce;
    flush     = fl;
    #1;
    // A word advances one stage when the slot ahead is free after this edge.
    ahead = ordy ? D + 1 : D;
    np = {};
    foreach (mpos[i]) begin
      np.push_back((ahead > mpos[i] + 1) ? mpos[i] + 1 : mpos[i]);
      ahead = np[i];
    end
    irdy   = ce && !fl && (np.size() == 0 || np[np.size()-1] > 0);
    exp_ov = (mpos.size() > 0) && (mpos[0] == D - 1);

    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) check("out_data", 64'(out_data), 64'(mdat[0]));
    else if (rst_pending) check("out_data_rstval", 64'(out_data), 64'(RV));
    rst_pending = 1'b0;
    check("in_ready", 64'(in_ready), 64'(irdy));
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("occ", 64'(occ), 64'(mpos.size()));
`endif
    $display("step iv=%0b id=%05h ordy=%0b ce=%0b fl=%0b | ov=%0b od=%05h ir=%0b",
             iv, id, ordy, ce, fl, out_valid, out_data, in_ready);

    if (ce) begin
      if (fl) begin
        mpos.delete();
        mdat.delete();
        rst_pending = 1'b1;
      end else begin
        mpos = np;
        if (mpos.size() > 0 && mpos[0] == D) begin
          void'(mpos.pop_front());
          void'(mdat.pop_front());
        end
        if (iv && irdy) begin
          mpos.push_back(0);
          mdat.push_back(id);
        end
      end
    end
    @(posedge clk);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before the next edge.
  task automatic async_rst();
    @(negedge clk);
    #2 RST = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(1'b0));
    check("arst_out_data", 64'(out_data), 64'(RV));
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("arst_occ", 64'(occ), 64'(0));
`endif
    $display("async reset pulse | ov=%0b od=%05h", out_valid, out_data);
    #1 RST = 1'b0;
    in_valid = 1'b0;
    mpos.delete();
    mdat.delete();
    rst_pending = 1'b1;
  endtask

  initial begin
    // Power-on reset held across edges.
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_data", 64'(out_data), 64'(RV));
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    RST = 1'b0;
    rst_pending = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Backpressure: five offered, three fit; then a pass-through cycle; then drain.
    for (int i = 11; i <= 15; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(16), 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Flush with a word offered in the same cycle.
    step(1'b1, W'(21), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(22), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(23), 1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Fill, then freeze with CE low (including a flush that must be ignored).
    for (int i = 31; i <= 33; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(34), 1'b1, 1'b0, 1'b0);
    step(1'b0, W'(35), 1'b1, 1'b0, 1'b1);
    step(1'b1, W'(36), 1'b0, 1'b0, 1'b0);
    step(1'b1, W'(37), 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Reset mid-stream.
    for (int i = 41; i <= 44; i++) step(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
    async_rst();
    repeat (3) step(1'b1, W'(50), 1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (n % 150 == 149) async_rst();
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
           ($urandom % 8) != 0, ($urandom % 32) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18: data width in bits, legal range 1..48.
REQ-002 The block SHALL have parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 The block SHALL have parameter RST_VAL, default 0: value loaded into every data stage at reset and flush.
REQ-004 Reset is RST, asynchronous, active-high; clock is clk. Port list follows.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port CE, input, 1 bit: global clock enable; low freezes all state.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of all stages.
REQ-009 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the chain accepts in_data this cycle.
REQ-011 The block SHALL have port in_data, input, WIDTH bits: upstream data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the last stage holds valid data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 The block SHALL have port out_data, output, WIDTH bits: last-stage data, driven directly from a register.

Function
REQ-015 Each stage i SHALL hold one data register and one valid bit v[i]; stage 0 takes input, stage DEPTH-1 drives the outputs.
REQ-016 Stage readiness SHALL be rdy[i] = !v[i] || rdy[i+1], with rdy[DEPTH] = out_ready; in_ready = CE && !flush && rdy[0] (combinational).
REQ-017 On each clk edge with CE=1 and flush=0, stage i SHALL load from stage i-1 (or from in_data for i=0) when rdy[i]=1; the loaded v[i] copies the source valid bit (in_valid for i=0).
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-019 Latency SHALL be exactly DEPTH cycles from input transfer to out_valid with no stalls; sustained throughput SHALL be 1 word per cycle.
REQ-020 With out_ready=0, bubbles SHALL collapse; in_ready SHALL go low only when all DEPTH stages are valid.
REQ-021 Full and out_ready=1 in the same cycle: the input transfer and the output transfer SHALL both occur (pass-through, no lost cycle).
REQ-022 CE=0 SHALL hold all registers and force in_ready=0; out_valid and out_data SHALL remain unchanged.
REQ-023 flush=1 with CE=1 SHALL clear all v[i] and load RST_VAL into all data at the next edge; flush SHALL override any concurrent transfer, and data offered that cycle is dropped.
REQ-024 flush=1 with CE=0 SHALL have no effect.
REQ-025 Data order SHALL be strictly preserved; no word SHALL be duplicated or lost outside flush and reset.

Reset
REQ-026 RST=1 SHALL immediately clear all v[i] and set all data registers to RST_VAL, regardless of clk and CE.
REQ-027 During and after reset, out_valid SHALL be 0 and out_data SHALL be RST_VAL; in_ready follows REQ-016.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight words; there SHALL be no partial recovery.

Configuration
REQ-029 Macro PIPE_REG_CHAIN_OCC_EN, when defined, SHALL add output port occ, width OCC_W(DEPTH), equal to the count of set v[i] bits (0..DEPTH), registered and updated on the same edge as the valid bits.
REQ-030 Without PIPE_REG_CHAIN_OCC_EN, port occ and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package pipe_pkg SHALL hold constant PIPE_MAX_DEPTH = 8 and function OCC_W(d) = clog2(d+1).
REQ-032 One stage (data, valid, ready term) SHALL be sub-module pipe_stage, instantiated DEPTH times in a generate loop.
REQ-033 An elaboration check SHALL reject DEPTH outside 1..PIPE_MAX_DEPTH and WIDTH outside 1..48.

Verification
REQ-034 Streaming: WIDTH=18, DEPTH=3, out_ready=1, inputs 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 appears starting on cycle 3, one word per cycle.
REQ-035 Backpressure: DEPTH=3, out_ready=0, 5 words offered -> exactly 3 accepted, then in_ready=0; with PIPE_REG_CHAIN_OCC_EN defined, occ=3; after out_ready=1, outputs are 1,2,3 in order.
REQ-036 Full pass-through: full chain with in_valid=1 and out_ready=1 in the same cycle -> one word in and one word out on that edge; occ stays 3.
REQ-037 Flush: 2 valid words and flush=1 with in_valid=1 -> next cycle out_valid=0, occ=0, out_data=RST_VAL; the offered word never appears.
REQ-038 Async reset: RST pulsed mid-stream between clock edges -> out_valid=0 and out_data=RST_VAL before the next edge; CE=0 for 4 cycles leaves outputs constant.
